// File: rtl/datapath_sequencer.sv
// Microcoded sequencer: 16-word loadable program drives regfile selects, ALU op, bus buffers and write enable.
// Two cycles per instruction (FETCH, EXEC). Optional macro SEQ_SINGLE_STEP_EN adds a step-gated PAUSE state.
module datapath_sequencer #(
  parameter int DEPTH = 16,
  parameter int IW    = 32,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          prog_we,
  input  logic [PW-1:0] prog_addr,
  input  logic [IW-1:0] prog_data,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic          step_mode,
  input  logic          step,
`endif
  output logic          busy,
  output logic          done,
  output logic [PW-1:0] pc,
  output logic [15:0]   initialR,
  output logic [3:0]    regWrite,
  output logic [3:0]    regRead1,
  output logic [3:0]    regRead2,
  output logic [7:0]    ALUOp,
  output logic [3:0]    buffCtrl,
  output logic          regWriteEn
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_DONE
`ifdef SEQ_SINGLE_STEP_EN
    , S_PAUSE
`endif
  } state_t;

  localparam logic [1:0] K_ALU  = 2'b00;
  localparam logic [1:0] K_LDI  = 2'b01;
  localparam logic [1:0] K_JMP  = 2'b10;
  localparam logic [1:0] K_HALT = 2'b11;

  state_t        state_q, state_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [1:0]    kind_q, kind_d;
  logic [PW-1:0] tgt_q, tgt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [15:0]   imm_q, imm_d;
  logic [3:0]    wr_q, wr_d;
  logic [3:0]    rd1_q, rd1_d;
  logic [3:0]    rd2_q, rd2_d;
  logic [7:0]    op_q, op_d;
  logic [3:0]    buf_q, buf_d;
  logic          we_q, we_d;

  logic [IW-1:0] mem_q [DEPTH];
  logic [IW-1:0] word;

  // Program RAM survives reset; writes are locked out while a run is active.
  always_ff @(posedge clk) begin
    if (prog_we && !busy_q) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  assign word = mem_q[pc_q];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kind_d  = kind_q;
    tgt_d   = tgt_q;
    imm_d   = '0;
    wr_d    = '0;
    rd1_d   = '0;
    rd2_d   = '0;
    op_d    = '0;
    buf_d   = '0;
    we_d    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH: begin
        // Decode here so the registered drive values hold for the entire EXEC cycle.
        state_d = S_EXEC;
        kind_d  = word[31:30];
        tgt_d   = word[PW-1:0];
        case (word[31:30])
          K_ALU: begin
            wr_d  = word[29:26];
            rd1_d = word[25:22];
            rd2_d = word[21:18];
            op_d  = word[17:10];
            buf_d = 4'b1110;
            we_d  = 1'b1;
          end
          K_LDI: begin
            wr_d  = word[29:26];
            imm_d = word[15:0];
            buf_d = 4'b0001;
            we_d  = 1'b1;
          end
          default: ;
        endcase
      end
      S_EXEC: begin
`ifdef SEQ_SINGLE_STEP_EN
        state_d = step_mode ? S_PAUSE : S_FETCH;
`else
        state_d = S_FETCH;
`endif
        case (kind_q)
          K_JMP:   pc_d = tgt_q;
          K_HALT:  state_d = S_DONE;
          default: pc_d = pc_q + 1'b1;
        endcase
      end
`ifdef SEQ_SINGLE_STEP_EN
      S_PAUSE: begin
        if (step) begin
          state_d = S_FETCH;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
`ifdef SEQ_SINGLE_STEP_EN
    busy_d = (state_d == S_FETCH) || (state_d == S_EXEC) || (state_d == S_PAUSE);
`else
    busy_d = (state_d == S_FETCH) || (state_d == S_EXEC);
`endif
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      kind_q  <= '0;
      tgt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      imm_q   <= '0;
      wr_q    <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      op_q    <= '0;
      buf_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kind_q  <= kind_d;
      tgt_q   <= tgt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      imm_q   <= imm_d;
      wr_q    <= wr_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      op_q    <= op_d;
      buf_q   <= buf_d;
      we_q    <= we_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pc         = pc_q;
  assign initialR   = imm_q;
  assign regWrite   = wr_q;
  assign regRead1   = rd1_q;
  assign regRead2   = rd2_q;
  assign ALUOp      = op_q;
  assign buffCtrl   = buf_q;
  assign regWriteEn = we_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer: a program model fills a per-cycle expected-output queue,
// and a regfile/ALU model driven by the sequencer outputs checks the computed register values.
module tb_datapath_sequencer;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic [3:0]  pc;
    logic [15:0] imm;
    logic [3:0]  wr;
    logic [3:0]  r1;
    logic [3:0]  r2;
    logic [7:0]  op;
    logic [3:0]  buff;
    logic        we;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = '0;
  logic [31:0] prog_data = '0;
  logic        busy, done, regWriteEn;
  logic [3:0]  pc, regWrite, regRead1, regRead2, buffCtrl;
  logic [15:0] initialR;
  logic [7:0]  ALUOp;

  datapath_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .busy(busy), .done(done), .pc(pc), .initialR(initialR),
    .regWrite(regWrite), .regRead1(regRead1), .regRead2(regRead2),
    .ALUOp(ALUOp), .buffCtrl(buffCtrl), .regWriteEn(regWriteEn)
  );

  always #5 clk = ~clk;

  obs_t cur;
  assign cur = {busy, done, pc, initialR, regWrite, regRead1, regRead2, ALUOp, buffCtrl, regWriteEn};

  int          n_chk = 0;
  int          n_pass = 0;
  obs_t        sb[$];
  logic [31:0] prog [16];
  logic [15:0] rf [16];
  bit          fib_on = 0;
  logic [15:0] fa, fb;

  function automatic logic [31:0] alu_w(input logic [3:0] rd, ra, rb, input logic [7:0] op);
    return {2'b00, rd, ra, rb, op, 10'b0};
  endfunction
  function automatic logic [31:0] ldi_w(input logic [3:0] rd, input logic [15:0] imm);
    return {2'b01, rd, 10'b0, imm};
  endfunction
  function automatic logic [31:0] jmp_w(input logic [3:0] t);
    return {2'b10, 26'b0, t};
  endfunction
  function automatic logic [31:0] halt_w();
    return {2'b11, 30'b0};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Expected per-cycle outputs for a run started at pc 0, from the program mirror.
  task automatic gen_trace(input int max_instr);
    logic [3:0]  p;
    logic [31:0] w;
    obs_t        e;
    p = 4'd0;
    for (int n = 0; n < max_instr; n++) begin
      w = prog[p];
      e = '0;
      e.busy = 1'b1;
      e.pc = p;
      sb.push_back(e);
      if (w[31:30] == 2'b00) begin
        e.wr = w[29:26]; e.r1 = w[25:22]; e.r2 = w[21:18]; e.op = w[17:10];
        e.buff = 4'b1110; e.we = 1'b1;
      end else if (w[31:30] == 2'b01) begin
        e.wr = w[29:26]; e.imm = w[15:0]; e.buff = 4'b0001; e.we = 1'b1;
      end
      sb.push_back(e);
      if (w[31:30] == 2'b11) begin
        e = '0;
        e.done = 1'b1;
        e.pc = p;
        sb.push_back(e);
        return;
      end else if (w[31:30] == 2'b10) begin
        p = w[3:0];
      end else begin
        p = p + 4'd1;
      end
    end
  endtask

  task automatic check_now();
    obs_t e;
    check("buff_excl", {63'b0, buffCtrl[0] & buffCtrl[3]}, 64'd0);
    if (regWriteEn === 1'b1) begin
      if (buffCtrl[0]) rf[regWrite] = initialR;
      else if (buffCtrl[3]) rf[regWrite] = (ALUOp == 8'h05) ? rf[regRead1] + rf[regRead2] : 16'h0;
      if (fib_on && regWrite == 4'd3) begin
        check("fib_r3", {48'b0, rf[3]}, {48'b0, fa + fb});
        fa = fb;
        fb = fa + rf[3] - fa;
        fb = rf[3];
      end
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("trace", 64'(cur), 64'(e));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_now();
  endtask

  task automatic load(input logic [3:0] a, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    prog[a] = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic run(input int max_instr);
    gen_trace(max_instr);
    start = 1'b1;
    tick();
    start = 1'b0;
    while (sb.size() > 0) tick();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      prog[i] = '0;
      rf[i] = '0;
    end
    #1;
    tick();
    tick();
    check("reset_state", 64'(cur), 64'd0);
    reset = 1'b0;
    tick();
    check("idle_state", 64'(cur), 64'd0);

    // LDI r1=1, LDI r2=1, ALU r3=r1+r2, HALT
    load(4'd0, ldi_w(4'd1, 16'd1));
    load(4'd1, ldi_w(4'd2, 16'd1));
    load(4'd2, alu_w(4'd3, 4'd1, 4'd2, 8'h05));
    load(4'd3, halt_w());
    run(4);
    check("progA_r1", {48'b0, rf[1]}, 64'd1);
    check("progA_r2", {48'b0, rf[2]}, 64'd1);
    check("progA_r3", {48'b0, rf[3]}, 64'd2);
    check("progA_done", {63'b0, done}, 64'd1);

    // Restart from DONE, reset during the ALU EXEC cycle
    gen_trace(4);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("midexec_we", {63'b0, regWriteEn}, 64'd1);
    sb.delete();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset_midexec", 64'(cur), 64'd0);

    // prog_we and start together in IDLE: first FETCH sees the new word
    prog[0] = halt_w();
    gen_trace(1);
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = halt_w(); start = 1'b1;
    tick();
    prog_we = 1'b0; start = 1'b0;
    while (sb.size() > 0) tick();
    check("we_start_done", {63'b0, done}, 64'd1);
    load(4'd0, ldi_w(4'd1, 16'd1));

    // Writes and start while busy are ignored
    gen_trace(4);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = halt_w(); start = 1'b1;
    tick();
    prog_we = 1'b0; start = 1'b0;
    while (sb.size() > 0) tick();
    run(4);
    check("rerun_r3", {48'b0, rf[3]}, 64'd2);

    // JMP 15 then LDI at word 15: pc wraps to 0 after the LDI
    reset = 1'b1;
    tick();
    reset = 1'b0;
    load(4'd0, jmp_w(4'd15));
    load(4'd15, ldi_w(4'd4, 16'hBEEF));
    run(5);
    check("wrap_r4", {48'b0, rf[4]}, 64'h0000_0000_0000_BEEF);
    check("wrap_busy", {63'b0, busy}, 64'd1);

    // Fibonacci loop, 20 iterations, never halts
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) rf[i] = '0;
    load(4'd0, ldi_w(4'd1, 16'd1));
    load(4'd1, ldi_w(4'd2, 16'd1));
    load(4'd2, alu_w(4'd3, 4'd1, 4'd2, 8'h05));
    load(4'd3, alu_w(4'd1, 4'd2, 4'd0, 8'h05));
    load(4'd4, alu_w(4'd2, 4'd3, 4'd0, 8'h05));
    load(4'd5, jmp_w(4'd2));
    fa = 16'd1;
    fb = 16'd1;
    fib_on = 1;
    run(2 + 4 * 20);
    fib_on = 0;
    check("fib_final_r3", {48'b0, rf[3]}, 64'd17711);
    check("fib_busy", {63'b0, busy}, 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("final_reset", 64'(cur), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
